// File: rtl/distram14_buf_pkg.sv
// Shared sizes and FSM state type for the distributed-RAM pre-trigger buffer.
package distram14_buf_pkg;

  localparam int unsigned SAMPLE_W = 14;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DEPTH    = 32;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    READ  = 2'd3
  } buf_state_t;

endpackage

// File: rtl/distram14_ram32.sv
// One 32-deep, 14-bit distributed RAM lane (RAM32M16 shape): port H is the
// write port addressed by wraddr; the read ports A-G share rdaddr and read
// asynchronously. DIH carries no data in this arrangement.
module distram14_ram32
  import distram14_buf_pkg::*;
(
  input  logic                clk_i,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wraddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [ADDR_W-1:0]   rdaddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  // Synchronous write through the ADDRH port.
  // NOTE: no reset on the storage array; distributed RAM has no reset path and
  // the contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[wraddr] <= wdata;
    end
  end

  assign rdata = mem[rdaddr];

endmodule

// File: rtl/distram14_pretrig_buffer.sv
// Circular history buffer: writes samples continuously, freezes a window of
// PRETRIG samples before and POSTTRIG after a trigger, then drains the window
// in time order over a valid/ready stream.
module distram14_pretrig_buffer
  import distram14_buf_pkg::*;
#(
  parameter int unsigned       NSAMP    = 1,
  parameter logic [ADDR_W-1:0] PRETRIG  = 5'd8,
  parameter logic [ADDR_W-1:0] POSTTRIG = 5'd7
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [SAMPLE_W*NSAMP-1:0] dat_i,
  input  logic                      trig_i,
  output logic                      armed_o,
  output logic                      busy_o,
  output logic [SAMPLE_W*NSAMP-1:0] dat_o,
  output logic                      valid_o,
  output logic                      last_o,
  input  logic                      ready_i
);

  localparam int unsigned LEN   = 32'(PRETRIG) + 32'(POSTTRIG) + 1;
  localparam logic [5:0]  LEN_C = LEN[5:0];

  if (LEN > DEPTH) begin : g_len_check
    $error("distram14_pretrig_buffer: PRETRIG+POSTTRIG+1 exceeds ring depth");
  end

  buf_state_t                state_q, state_d;
  logic [ADDR_W-1:0]         wraddr, rdaddr, trigaddr, trig_base;
  logic [ADDR_W-1:0]         fill_cnt, post_cnt;
  logic [5:0]                issued;
  logic                      wr_en, fill_done, post_done, rd_load, rd_done;
  logic [SAMPLE_W*NSAMP-1:0] ram_rd;

  assign wr_en     = (state_q != READ);
  assign fill_done = (6'(fill_cnt) + 6'd1 >= 6'(PRETRIG));
  assign post_done = (post_cnt == POSTTRIG - 5'd1);
  assign rd_load   = (state_q == READ) && (!valid_o || ready_i) && (issued < LEN_C);
  assign rd_done   = (state_q == READ) && valid_o && ready_i && last_o;
  // The trigger address is taken live from wraddr on the direct ARMED->READ path.
  assign trig_base = (state_q == ARMED) ? wraddr : trigaddr;

  for (genvar s = 0; s < NSAMP; s++) begin : g_ram
    distram14_ram32 u_ram (
      .clk_i  (clk_i),
      .we     (wr_en),
      .wraddr (wraddr),
      .wdata  (dat_i[s*SAMPLE_W +: SAMPLE_W]),
      .rdaddr (rdaddr),
      .rdata  (ram_rd[s*SAMPLE_W +: SAMPLE_W])
    );
  end

  // State register plus registered status decodes of the upcoming state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= FILL;
      armed_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_o <= (state_d == ARMED);
      busy_o  <= (state_d == POST) || (state_d == READ);
    end
  end

  // Next-state decode.
  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (fill_done) state_d = ARMED;
      ARMED:   if (trig_i) state_d = (POSTTRIG == '0) ? READ : POST;
      POST:    if (post_done) state_d = READ;
      READ:    if (rd_done) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Write pointer, phase counters, trigger address and read pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wraddr   <= '0;
      rdaddr   <= '0;
      trigaddr <= '0;
      fill_cnt <= '0;
      post_cnt <= '0;
      issued   <= '0;
    end else begin
      if (wr_en) begin
        wraddr <= wraddr + 5'd1;
      end
      fill_cnt <= (state_q == FILL) ? fill_cnt + 5'd1 : '0;
      post_cnt <= (state_q == POST) ? post_cnt + 5'd1 : '0;
      if (state_q == ARMED && trig_i) begin
        trigaddr <= wraddr;
      end
      if (state_q != READ && state_d == READ) begin
        rdaddr <= trig_base - PRETRIG;
        issued <= '0;
      end else if (rd_load) begin
        rdaddr <= rdaddr + 5'd1;
        issued <= issued + 6'd1;
      end
    end
  end

  // Registered readout stage with backpressure hold.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      dat_o   <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else if (rd_load) begin
      dat_o   <= ram_rd;
      valid_o <= 1'b1;
      last_o  <= (issued == LEN_C - 6'd1);
    end else if (state_q == READ && ready_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_distram14_pretrig_buffer.sv
// Self-checking bench: instance 0 uses PRETRIG=4/POSTTRIG=3 for the directed
// scenarios plus random traffic; instance 1 uses PRETRIG=0/POSTTRIG=0 under
// random traffic. A window-level reference model predicts every beat.
module tb_distram14_pretrig_buffer;

  typedef enum int {M_FILL, M_ARMED, M_POST, M_READ} mphase_t;

  logic        clk_i = 1'b0;
  logic        rst_n [2];
  logic        trig  [2];
  logic        ready [2];
  logic [13:0] din   [2];
  logic [13:0] dout  [2];
  logic        valid [2];
  logic        last  [2];
  logic        armed [2];
  logic        busy  [2];

  always #5 clk_i = ~clk_i;

  distram14_pretrig_buffer #(.NSAMP(1), .PRETRIG(5'd4), .POSTTRIG(5'd3)) dut_a (
    .clk_i(clk_i), .rst_n_i(rst_n[0]), .dat_i(din[0]), .trig_i(trig[0]),
    .armed_o(armed[0]), .busy_o(busy[0]), .dat_o(dout[0]), .valid_o(valid[0]),
    .last_o(last[0]), .ready_i(ready[0])
  );

  distram14_pretrig_buffer #(.NSAMP(1), .PRETRIG(5'd0), .POSTTRIG(5'd0)) dut_b (
    .clk_i(clk_i), .rst_n_i(rst_n[1]), .dat_i(din[1]), .trig_i(trig[1]),
    .armed_o(armed[1]), .busy_o(busy[1]), .dat_o(dout[1]), .valid_o(valid[1]),
    .last_o(last[1]), .ready_i(ready[1])
  );

  // Reference model state
  mphase_t     phase    [2];
  int          fill_n   [2];
  int          post_n   [2];
  int          read_age [2];
  int          beats    [2];
  int          lasts    [2];
  logic [13:0] cnt      [2];
  logic [13:0] exp_q    [2][$];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int pre_of(int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic int post_of(int i);
    return (i == 0) ? 3 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  // One clock: sample pre-edge signals, step the model, check post-edge outputs.
  task automatic tick();
    logic        pv [2], pl [2], pr [2], pt [2], prst [2];
    logic [13:0] pd [2], pin [2];
    for (int i = 0; i < 2; i++) begin
      pv[i] = valid[i]; pl[i] = last[i]; pd[i] = dout[i];
      pr[i] = ready[i]; pt[i] = trig[i]; prst[i] = rst_n[i]; pin[i] = din[i];
    end
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!prst[i]) begin
        phase[i] = M_FILL; fill_n[i] = 0; post_n[i] = 0; cnt[i] = '0;
        exp_q[i].delete();
        check($sformatf("rst_valid%0d", i), valid[i], 0);
        check($sformatf("rst_busy%0d", i), busy[i], 0);
        check($sformatf("rst_armed%0d", i), armed[i], 0);
        check($sformatf("rst_dat%0d", i), dout[i], 0);
      end else begin
        cnt[i] = cnt[i] + 14'd1;
        if (phase[i] == M_READ) read_age[i]++;
        if (pv[i] && !pr[i]) begin
          check($sformatf("stall_dat%0d", i), dout[i], pd[i]);
          check($sformatf("stall_last%0d", i), last[i], pl[i]);
          check($sformatf("stall_valid%0d", i), valid[i], 1);
        end
        case (phase[i])
          M_FILL: begin
            fill_n[i]++;
            if (fill_n[i] >= ((pre_of(i) == 0) ? 1 : pre_of(i))) phase[i] = M_ARMED;
          end
          M_ARMED: if (pt[i]) begin
            for (int k = 0; k <= pre_of(i) + post_of(i); k++)
              exp_q[i].push_back(pin[i] - 14'(pre_of(i)) + 14'(k));
            post_n[i] = 0;
            if (post_of(i) == 0) begin phase[i] = M_READ; read_age[i] = 0; end
            else phase[i] = M_POST;
          end
          M_POST: begin
            post_n[i]++;
            if (post_n[i] == post_of(i)) begin phase[i] = M_READ; read_age[i] = 0; end
          end
          M_READ: if (pv[i] && pr[i] && exp_q[i].size() > 0) begin
            check($sformatf("beat_dat%0d", i), pd[i], exp_q[i][0]);
            check($sformatf("beat_last%0d", i), pl[i], (exp_q[i].size() == 1) ? 1 : 0);
            if (pl[i]) lasts[i]++;
            void'(exp_q[i].pop_front());
            beats[i]++;
            if (exp_q[i].size() == 0) begin phase[i] = M_FILL; fill_n[i] = 0; end
          end
          default: phase[i] = M_FILL;
        endcase
        check($sformatf("armed%0d", i), armed[i], (phase[i] == M_ARMED) ? 1 : 0);
        check($sformatf("busy%0d", i), busy[i],
              (phase[i] == M_POST || phase[i] == M_READ) ? 1 : 0);
        if (phase[i] != M_READ || read_age[i] == 0)
          check($sformatf("valid_idle%0d", i), valid[i], 0);
        else if ((pr[i] || !pv[i]) && exp_q[i].size() > 0)
          check($sformatf("valid_flow%0d", i), valid[i], 1);
      end
      din[i] = cnt[i];
    end
  endtask

  // Advance one cycle with random traffic on instance 1.
  task automatic cyc();
    trig[1]  = ($urandom_range(0, 3) == 0);
    ready[1] = ($urandom_range(0, 3) != 0);
    tick();
  endtask

  task automatic idle_a(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic reset_a();
    rst_n[0] = 1'b0;
    cyc(); cyc();
    rst_n[0] = 1'b1;
  endtask

  // Pulse trig on instance 0 for the cycle whose sample equals n.
  task automatic pulse_a(input int n);
    for (int k = 0; k < 300 && int'(cnt[0]) != n; k++) cyc();
    check("reach_cnt", 32'(cnt[0]), n);
    trig[0] = 1'b1;
    cyc();
    trig[0] = 1'b0;
  endtask

  int b0, l0, b1_start;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; trig[i] = 1'b0; ready[i] = 1'b1; din[i] = '0;
      phase[i] = M_FILL; fill_n[i] = 0; post_n[i] = 0; read_age[i] = 0;
      beats[i] = 0; lasts[i] = 0; cnt[i] = '0;
    end
    tick(); tick(); tick();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    b1_start = beats[1];

    // Basic capture: window 16..23
    b0 = beats[0];
    pulse_a(20);
    idle_a(15);
    check("basic_beats", beats[0] - b0, 8);

    // Trigger during FILL is ignored; later trigger captures 6..13
    reset_a();
    b0 = beats[0];
    pulse_a(2);
    pulse_a(10);
    idle_a(15);
    check("ignored_beats", beats[0] - b0, 8);

    // Backpressure with ready pattern 1,0,0
    reset_a();
    b0 = beats[0]; l0 = lasts[0];
    pulse_a(20);
    for (int k = 0; k < 40; k++) begin
      ready[0] = (k % 3 == 0);
      cyc();
    end
    ready[0] = 1'b1;
    idle_a(5);
    check("bp_beats", beats[0] - b0, 8);
    check("bp_lasts", lasts[0] - l0, 1);

    // Wrap: trigger sample at address 1, window at 29..31,0..4
    reset_a();
    b0 = beats[0];
    pulse_a(33);
    idle_a(15);
    check("wrap_beats", beats[0] - b0, 8);

    // Reset while the third beat is presented, then a clean capture
    reset_a();
    b0 = beats[0];
    pulse_a(20);
    for (int k = 0; k < 30 && !((beats[0] - b0) == 2 && valid[0]); k++) cyc();
    check("mid_reach", beats[0] - b0, 2);
    reset_a();
    b0 = beats[0];
    pulse_a(20);
    idle_a(15);
    check("after_rst_beats", beats[0] - b0, 8);

    // Random traffic on both instances
    for (int k = 0; k < 3000; k++) begin
      trig[0]  = ($urandom_range(0, 9) == 0);
      ready[0] = ($urandom_range(0, 9) < 7);
      cyc();
    end

    // Drain both instances
    trig[0] = 1'b0; ready[0] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      trig[1] = 1'b0; ready[1] = 1'b1;
      tick();
    end
    check("drain_a", exp_q[0].size(), 0);
    check("drain_b", exp_q[1].size(), 0);
    check("b_captured", (beats[1] - b1_start > 20) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/distram14_pretrig_buffer.md
# distram14_pretrig_buffer

Distributed-RAM circular history buffer for 14-bit samples, NSAMP per clock, with a trigger-driven capture and a valid/ready readout stream. Samples are written continuously into a 32-deep RAM32M16 ring. On trigger, PRETRIG samples before and POSTTRIG samples after the trigger are frozen, then drained in time order. It complements the fixed distram delay lines: where those write and read at a constant offset, this block writes freely and reads back on demand under handshake.

## Interface
- NSAMP, 1, samples per clock. Each sample is 14 bits, one RAM32M16 per sample.
- PRETRIG, 5'd8, samples captured before the trigger sample.
- POSTTRIG, 5'd7, samples captured after the trigger sample.
- Legality: LEN = PRETRIG+POSTTRIG+1 must be ≤ 32. Elaboration fails otherwise.

Ports:
- clk_i  in  1  the single clock.
- rst_n_i  in  1  reset: synchronous, active-low.
- dat_i  in  14*NSAMP  input sample word, written every clock while writing is enabled.
- trig_i  in  1  trigger, single-cycle qualified.
- armed_o  out  1  high in ARMED; trig_i is accepted.
- busy_o  out  1  high in POST or READ.
- dat_o  out  14*NSAMP  readout word, registered.
- valid_o  out  1  dat_o valid.
- last_o  out  1  final word of the window.
- ready_i  in  1  downstream accept.

## Operation
States: FILL, ARMED, POST, READ.
- **FILL**: write dat_i at wraddr and increment wraddr every clock. After PRETRIG writes, go to ARMED. If PRETRIG=0, go to ARMED on the next cycle. trig_i is ignored.
- **ARMED**: keep writing. On trig_i=1, latch trigaddr=wraddr, which is the trigger sample's address. Then go to POST, or go directly to READ if POSTTRIG=0.
- **POST**: write POSTTRIG more samples, then go to READ. trig_i is ignored.
- **READ**:
  - RAM write enable is 0.
  - rdaddr is initialised to trigaddr−PRETRIG mod 32.
  - The output register loads when (!valid_o || ready_i) and issued<LEN. On load: dat_o←RAM[rdaddr], valid_o←1, last_o←(issued==LEN−1), then increment rdaddr and issued.
  - If no load occurs and ready_i=1, valid_o←0 and last_o←0.
  - When valid_o && ready_i && last_o, go to FILL and clear the fill count. wraddr continues from its current value.
- Arithmetic: wraddr, rdaddr and trigaddr are 5-bit and wrap modulo 32. issued is 6-bit.
- Reset (rst_n_i=0 at a clock edge):
  - state=FILL; wraddr=0, rdaddr=0, issued=0.
  - Outputs: valid_o=0, last_o=0, dat_o=0, armed_o=0, busy_o=0.
  - RAM contents are unspecified.
  - Reset during READ aborts the readout: valid_o is 0 after that edge, and no partial-window continuation occurs.

## Timing
- trig_i is sampled at edge T; the trigger sample is dat_i at T.
- POST writes occur at T+1 … T+POSTTRIG. READ is entered after edge T+POSTTRIG.
- First valid_o=1 after edge T+POSTTRIG+1, giving 1-cycle read latency.
- With ready_i held high, the stream is LEN consecutive beats with no gaps.
- Throughput is one word per clock. Backpressure holds dat_o, valid_o and last_o stable while valid_o && !ready_i.
- armed_o and busy_o are registered decodes of the state.
- Simultaneous cases:
  - trig_i on the FILL→ARMED transition edge is ignored.
  - trig_i during POST or READ is ignored and not queued.
- Wrap: a window that straddles address 31→0 is read in time order.

## Structure
- Package distram14_buf_pkg holds:
  - SAMPLE_W=14, ADDR_W=5, DEPTH=32;
  - the state enum type (FILL, ARMED, POST, READ).
- Sub-module distram14_ram32: one RAM32M16 per sample.
  - Write port: ADDRH with WE.
  - Ports A–G take rdaddr; DIH is tied to 0.
  - Read is combinational.
  - The top level instantiates it NSAMP times via generate.
- The top level holds the FSM, the counters and the output register.

## Test plan
All scenarios use NSAMP=1 and dat_i=free-running cycle counter since reset release.
- **Basic capture**: PRETRIG=4, POSTTRIG=3, ready_i=1, trig_i at counter=20 → 8 beats 16..23, last_o on 23, first valid_o 4 cycles after trigger edge.
- **Ignored trigger**: trig_i at counter=2, while still in FILL → armed_o=0 and no capture. A second trig_i at counter=10 → beats 6..13.
- **Backpressure**: ready_i toggles 1,0,0,1,… during READ → dat_o stable while stalled, sequence 16..23 intact, exactly one last_o.
- **Wrap-around**: arrange trigaddr=1 with PRETRIG=4 → reads addresses 29,30,31,0,1,… in time order, values contiguous.
- **Extremes and re-arm**: PRETRIG=0, POSTTRIG=0 → single beat with last_o=1 equal to the trigger sample. The block then re-enters FILL and accepts a second trigger.
- **Reset mid-readout**: rst_n_i=0 during the 3rd beat → next cycle valid_o=0, busy_o=0, armed_o=0. The subsequent capture is correct.
